// File: rtl/gpio_bank_ctl.sv
// GPIO bank controller: SFR-programmed pad controls, 2-flop input sync, per-channel debounce,
// edge capture into W1C STATUS and a single irq. Define GPIOB_LEVEL_IRQ_EN to add the LVL register.
module gpio_bank_ctl #(
  parameter int NCH = 7,
  parameter int DBW = 4
) (
  input  logic           i_clk,
  input  logic           i_rstz,
  input  logic [3:0]     sfr_addr,
  input  logic           sfr_wr,
  input  logic [7:0]     sfr_wdat,
  output logic [7:0]     sfr_rdat,
  input  logic [NCH-1:0] di_gpio,
  output logic [NCH-1:0] do_gpio,
  output logic [NCH-1:0] oe_gpio,
  output logic [NCH-1:0] pu_gpio,
  output logic [NCH-1:0] pd_gpio,
  output logic [NCH-1:0] ie_gpio,
  output logic           irq
);

  localparam logic [3:0] A_OE     = 4'd0;
  localparam logic [3:0] A_DO     = 4'd1;
  localparam logic [3:0] A_PU     = 4'd2;
  localparam logic [3:0] A_PD     = 4'd3;
  localparam logic [3:0] A_IE     = 4'd4;
  localparam logic [3:0] A_DBEN   = 4'd5;
  localparam logic [3:0] A_RISE   = 4'd6;
  localparam logic [3:0] A_FALL   = 4'd7;
  localparam logic [3:0] A_STATUS = 4'd8;
  localparam logic [3:0] A_FILT   = 4'd9;
  localparam logic [3:0] A_DBTHR  = 4'd10;
`ifdef GPIOB_LEVEL_IRQ_EN
  localparam logic [3:0] A_LVL    = 4'd11;
`endif

  logic [NCH-1:0] oe_q, do_q, pu_q, pd_q, ie_q, dben_q, rise_q, fall_q;
  logic [NCH-1:0] status_q, status_d;
  logic [DBW-1:0] dbthr_q;
  logic [NCH-1:0] s1_q, s2_q;
  logic [NCH-1:0] filt_q, filt_d, filt_dly_q;
  logic [DBW-1:0] cnt_q [NCH];
  logic [DBW-1:0] cnt_d [NCH];
`ifdef GPIOB_LEVEL_IRQ_EN
  logic [NCH-1:0] lvl_q;
`endif

  logic [NCH-1:0] wdat_ch;
  logic [DBW-1:0] wdat_thr;
  logic           unused_wdat;
  logic           wr_oe, wr_do, wr_pu, wr_pd, wr_ie, wr_dben, wr_rise, wr_fall;
  logic           wr_status, wr_dbthr;
  logic [NCH-1:0] rise_ev, fall_ev, stat_set, stat_clr;

  assign wdat_ch     = sfr_wdat[NCH-1:0];
  assign wdat_thr    = sfr_wdat[DBW-1:0];
  assign unused_wdat = ^sfr_wdat;

  assign wr_oe     = sfr_wr && (sfr_addr == A_OE);
  assign wr_do     = sfr_wr && (sfr_addr == A_DO);
  assign wr_pu     = sfr_wr && (sfr_addr == A_PU);
  assign wr_pd     = sfr_wr && (sfr_addr == A_PD);
  assign wr_ie     = sfr_wr && (sfr_addr == A_IE);
  assign wr_dben   = sfr_wr && (sfr_addr == A_DBEN);
  assign wr_rise   = sfr_wr && (sfr_addr == A_RISE);
  assign wr_fall   = sfr_wr && (sfr_addr == A_FALL);
  assign wr_status = sfr_wr && (sfr_addr == A_STATUS);
  assign wr_dbthr  = sfr_wr && (sfr_addr == A_DBTHR);

  always_ff @(posedge i_clk or negedge i_rstz) begin
    if (!i_rstz) begin
      oe_q    <= '0;
      do_q    <= '0;
      pu_q    <= '0;
      pd_q    <= '0;
      ie_q    <= '1;
      dben_q  <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      dbthr_q <= '0;
    end else begin
      if (wr_oe)    oe_q    <= wdat_ch;
      if (wr_do)    do_q    <= wdat_ch;
      if (wr_pu)    pu_q    <= wdat_ch;
      if (wr_pd)    pd_q    <= wdat_ch;
      if (wr_ie)    ie_q    <= wdat_ch;
      if (wr_dben)  dben_q  <= wdat_ch;
      if (wr_rise)  rise_q  <= wdat_ch;
      if (wr_fall)  fall_q  <= wdat_ch;
      if (wr_dbthr) dbthr_q <= wdat_thr;
    end
  end

`ifdef GPIOB_LEVEL_IRQ_EN
  logic wr_lvl;
  assign wr_lvl = sfr_wr && (sfr_addr == A_LVL);

  always_ff @(posedge i_clk or negedge i_rstz) begin
    if (!i_rstz)     lvl_q <= '0;
    else if (wr_lvl) lvl_q <= wdat_ch;
  end
`endif

  // Conflicting pull requests leave the pad floating rather than fighting itself.
  assign oe_gpio = oe_q;
  assign do_gpio = do_q;
  assign ie_gpio = ie_q;
  assign pu_gpio = pu_q & ~pd_q;
  assign pd_gpio = pd_q & ~pu_q;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = cnt_q[i];
      if (!dben_q[i]) begin
        filt_d[i] = s2_q[i];
        cnt_d[i]  = '0;
      end else if (s2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= dbthr_q) begin
        // >= so that lowering DBTHR below a running count releases at once.
        filt_d[i] = s2_q[i];
        cnt_d[i]  = '0;
      end else if (cnt_q[i] != '1) begin
        cnt_d[i] = cnt_q[i] + DBW'(1);
      end
      if (!ie_q[i]) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstz) begin
    if (!i_rstz) begin
      s1_q       <= '0;
      s2_q       <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q       <= di_gpio & ie_q;
      s2_q       <= s1_q & ie_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign rise_ev  = filt_q & ~filt_dly_q;
  assign fall_ev  = ~filt_q & filt_dly_q;
  assign stat_set = (rise_ev & rise_q) | (fall_ev & fall_q);
  assign stat_clr = wr_status ? wdat_ch : '0;

  always_comb begin
    status_d = (status_q & ~stat_clr) | stat_set;
`ifdef GPIOB_LEVEL_IRQ_EN
    // Level channels mirror the selected polarity of filt and ignore W1C.
    status_d = (status_d & ~lvl_q) | (lvl_q & ((filt_q & rise_q) | (~filt_q & fall_q)));
`endif
  end

  always_ff @(posedge i_clk or negedge i_rstz) begin
    if (!i_rstz) status_q <= '0;
    else         status_q <= status_d;
  end

  assign irq = |status_q;

  always_comb begin
    sfr_rdat = '0;
    case (sfr_addr)
      A_OE:     sfr_rdat[NCH-1:0] = oe_q;
      A_DO:     sfr_rdat[NCH-1:0] = do_q;
      A_PU:     sfr_rdat[NCH-1:0] = pu_q;
      A_PD:     sfr_rdat[NCH-1:0] = pd_q;
      A_IE:     sfr_rdat[NCH-1:0] = ie_q;
      A_DBEN:   sfr_rdat[NCH-1:0] = dben_q;
      A_RISE:   sfr_rdat[NCH-1:0] = rise_q;
      A_FALL:   sfr_rdat[NCH-1:0] = fall_q;
      A_STATUS: sfr_rdat[NCH-1:0] = status_q;
      A_FILT:   sfr_rdat[NCH-1:0] = filt_q;
      A_DBTHR:  sfr_rdat[DBW-1:0] = dbthr_q;
`ifdef GPIOB_LEVEL_IRQ_EN
      A_LVL:    sfr_rdat[NCH-1:0] = lvl_q;
`endif
      default:  sfr_rdat = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_bank_ctl.sv
// Testbench for gpio_bank_ctl: register/pad vector table through a scoreboard queue,
// then hand sequences for input timing, debounce, W1C races, IE gating and reset.
module tb_gpio_bank_ctl;
  localparam int NCH = 7;
  localparam int DBW = 4;

  logic           i_clk = 1'b0;
  logic           i_rstz = 1'b0;
  logic [3:0]     sfr_addr = '0;
  logic           sfr_wr = 1'b0;
  logic [7:0]     sfr_wdat = '0;
  logic [7:0]     sfr_rdat;
  logic [NCH-1:0] di_gpio = '0;
  logic [NCH-1:0] do_gpio, oe_gpio, pu_gpio, pd_gpio, ie_gpio;
  logic           irq;

  gpio_bank_ctl #(.NCH(NCH), .DBW(DBW)) dut (
    .i_clk(i_clk), .i_rstz(i_rstz),
    .sfr_addr(sfr_addr), .sfr_wr(sfr_wr), .sfr_wdat(sfr_wdat), .sfr_rdat(sfr_rdat),
    .di_gpio(di_gpio), .do_gpio(do_gpio), .oe_gpio(oe_gpio), .pu_gpio(pu_gpio),
    .pd_gpio(pd_gpio), .ie_gpio(ie_gpio), .irq(irq)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] wdat;
    logic [7:0] oe, dout, pu, pd, ie, rd;
  } vec_t;

  vec_t vecs[12];
  vec_t sb_q[$];
  vec_t e;
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
    sfr_addr = a;
    #1;
    chk(name, sfr_rdat, exp);
  endtask

  task automatic sfr_write(input logic [3:0] a, input logic [7:0] d);
    sfr_addr = a;
    sfr_wdat = d;
    sfr_wr = 1'b1;
    @(posedge i_clk);
    #1;
    sfr_wr = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'd0,  8'h55, 8'h55, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h55};
    vecs[1]  = '{4'd1,  8'h2A, 8'h55, 8'h2A, 8'h00, 8'h00, 8'h7F, 8'h2A};
    vecs[2]  = '{4'd2,  8'h05, 8'h55, 8'h2A, 8'h05, 8'h00, 8'h7F, 8'h05};
    vecs[3]  = '{4'd3,  8'h04, 8'h55, 8'h2A, 8'h01, 8'h00, 8'h7F, 8'h04};
    vecs[4]  = '{4'd3,  8'h0A, 8'h55, 8'h2A, 8'h05, 8'h0A, 8'h7F, 8'h0A};
    vecs[5]  = '{4'd0,  8'hFF, 8'h7F, 8'h2A, 8'h05, 8'h0A, 8'h7F, 8'h7F};
    vecs[6]  = '{4'd12, 8'hFF, 8'h7F, 8'h2A, 8'h05, 8'h0A, 8'h7F, 8'h00};
    vecs[7]  = '{4'd10, 8'hFF, 8'h7F, 8'h2A, 8'h05, 8'h0A, 8'h7F, 8'h0F};
    vecs[8]  = '{4'd10, 8'h00, 8'h7F, 8'h2A, 8'h05, 8'h0A, 8'h7F, 8'h00};
    vecs[9]  = '{4'd4,  8'h7E, 8'h7F, 8'h2A, 8'h05, 8'h0A, 8'h7E, 8'h7E};
    vecs[10] = '{4'd4,  8'h7F, 8'h7F, 8'h2A, 8'h05, 8'h0A, 8'h7F, 8'h7F};
    vecs[11] = '{4'd9,  8'hFF, 8'h7F, 8'h2A, 8'h05, 8'h0A, 8'h7F, 8'h00};

    #22 i_rstz = 1'b1;
    @(negedge i_clk);

    // Reset values
    chk("rst_oe", 8'(oe_gpio), 8'h00);
    chk("rst_do", 8'(do_gpio), 8'h00);
    chk("rst_pu", 8'(pu_gpio), 8'h00);
    chk("rst_pd", 8'(pd_gpio), 8'h00);
    chk("rst_ie", 8'(ie_gpio), 8'h7F);
    chk("rst_irq", 8'(irq), 8'h00);
    rd_chk("rst_rd_ie", 4'd4, 8'h7F);

    // Register/pad table via scoreboard
    for (int i = 0; i < 12; i++) begin
      sb_q.push_back(vecs[i]);
      sfr_write(vecs[i].addr, vecs[i].wdat);
      e = sb_q.pop_front();
      chk($sformatf("v%0d_oe", i), 8'(oe_gpio), e.oe);
      chk($sformatf("v%0d_do", i), 8'(do_gpio), e.dout);
      chk($sformatf("v%0d_pu", i), 8'(pu_gpio), e.pu);
      chk($sformatf("v%0d_pd", i), 8'(pd_gpio), e.pd);
      chk($sformatf("v%0d_ie", i), 8'(ie_gpio), e.ie);
      rd_chk($sformatf("v%0d_rd", i), e.addr, e.rd);
    end

    // A: no-debounce input timing, rise capture, W1C
    sfr_write(4'd6, 8'h01);
    di_gpio[0] = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    rd_chk("a_filt_e1", 4'd9, 8'h00);
    cycles(1);
    rd_chk("a_filt_e2", 4'd9, 8'h01);
    chk("a_irq_e2", 8'(irq), 8'h00);
    cycles(1);
    chk("a_irq_e3", 8'(irq), 8'h01);
    rd_chk("a_status_e3", 4'd8, 8'h01);
    sfr_write(4'd8, 8'h01);
    chk("a_irq_w1c", 8'(irq), 8'h00);
    rd_chk("a_status_w1c", 4'd8, 8'h00);

    // B: debounce ch1, DBTHR=3, fall enabled
    sfr_write(4'd7, 8'h02);
    sfr_write(4'd10, 8'h03);
    sfr_write(4'd5, 8'h02);
    di_gpio[1] = 1'b1;
    cycles(10);
    rd_chk("b_filt_hi", 4'd9, 8'h03);
    rd_chk("b_status_hi", 4'd8, 8'h00);
    di_gpio[1] = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    di_gpio[1] = 1'b1;
    cycles(10);
    rd_chk("b_pulse_status", 4'd8, 8'h00);
    rd_chk("b_pulse_filt", 4'd9, 8'h03);
    di_gpio[1] = 1'b0;
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    rd_chk("b_filt_e4", 4'd9, 8'h03);
    cycles(1);
    rd_chk("b_filt_e5", 4'd9, 8'h01);
    rd_chk("b_status_e5", 4'd8, 8'h00);
    cycles(1);
    rd_chk("b_status_e6", 4'd8, 8'h02);
    chk("b_irq_e6", 8'(irq), 8'h01);
    sfr_write(4'd8, 8'h02);
    rd_chk("b_status_clr", 4'd8, 8'h00);

    // C: rising edge lands on the same clock as a W1C of that bit
    di_gpio[0] = 1'b0;
    cycles(5);
    rd_chk("c_status_pre", 4'd8, 8'h00);
    di_gpio[0] = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    sfr_write(4'd8, 8'h01);
    rd_chk("c_status_race", 4'd8, 8'h01);
    chk("c_irq_race", 8'(irq), 8'h01);
    sfr_write(4'd8, 8'h01);
    chk("c_irq_clr", 8'(irq), 8'h00);

    // D: IE=0 on ch2 blocks input
    sfr_write(4'd4, 8'h7B);
    sfr_write(4'd6, 8'h05);
    sfr_write(4'd7, 8'h06);
    for (int k = 0; k < 6; k++) begin
      di_gpio[2] = ~di_gpio[2];
      cycles(4);
      rd_chk($sformatf("d_filt_%0d", k), 4'd9, 8'h01);
    end
    rd_chk("d_status", 4'd8, 8'h00);
    sfr_write(4'd4, 8'h7F);

    // F: lowering DBTHR below a running count releases filt next cycle
    sfr_write(4'd10, 8'h07);
    di_gpio[1] = 1'b1;
    repeat (4) @(posedge i_clk);
    @(negedge i_clk);
    sfr_write(4'd10, 8'h02);
    rd_chk("f_filt_wr", 4'd9, 8'h01);
    cycles(1);
    rd_chk("f_filt_next", 4'd9, 8'h03);

    // E: reset mid-debounce with a pending status bit
    di_gpio[1] = 1'b0;
    cycles(12);
    rd_chk("e_status_pre", 4'd8, 8'h02);
    di_gpio[1] = 1'b1;
    cycles(2);
    i_rstz = 1'b0;
    #1;
    chk("e_irq_rst", 8'(irq), 8'h00);
    rd_chk("e_filt_rst", 4'd9, 8'h00);
    rd_chk("e_status_rst", 4'd8, 8'h00);
    chk("e_ie_rst", 8'(ie_gpio), 8'h7F);
    @(negedge i_clk);
    i_rstz = 1'b1;
    cycles(6);
    rd_chk("e_filt_post", 4'd9, 8'h03);
    rd_chk("e_status_post", 4'd8, 8'h00);
    chk("e_irq_post", 8'(irq), 8'h00);

`ifdef GPIOB_LEVEL_IRQ_EN
    sfr_write(4'd6, 8'h01);
    sfr_write(4'd11, 8'h01);
    cycles(1);
    rd_chk("m_status_lvl", 4'd8, 8'h01);
    sfr_write(4'd8, 8'h01);
    rd_chk("m_status_w1c", 4'd8, 8'h01);
    chk("m_irq_lvl", 8'(irq), 8'h01);
`else
    sfr_write(4'd11, 8'hFF);
    rd_chk("m_addr11", 4'd11, 8'h00);
`endif

    chk("sb_empty", 8'(sb_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
